seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered ALU for the wider CPU datapath. It keeps the existing six-operation encoding and adds shifts, a multi-cycle shift-add multiply, full NZCV flags and a valid/ready input handshake. It sits between the register file read ports and the writeback mux. Results and flags are held until the next completed operation.

Parameters:
WIDTH, 8, operand/result width; power of 2, minimum 4
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept an op this cycle
alu_op  input  4  operation select
operand_a  input  WIDTH  first operand
operand_b  input  WIDTH  second operand / shift amount (low SHW bits)
result  output  WIDTH  registered result (low half for MUL)
result_hi  output  WIDTH  high half of MUL product; 0 for all other ops
done  output  1  one-cycle pulse: result/flags updated this cycle
busy  output  1  multiply in progress
zero_flag  output  1  result == 0 (full 2*WIDTH product for MUL)
carry_flag  output  1  carry/borrow/shift-out (see below)
negative_flag  output  1  result[WIDTH-1]
overflow_flag  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Single clock (clk). Reset is synchronous, active-high.
- Reset: state IDLE; result, result_hi, all flags, done, busy = 0. The multiply counter and accumulators clear. in_ready=1 from the first cycle after rst deasserts. in_valid is ignored while rst=1.
- Reset asserted mid-multiply aborts the operation. No done pulse. Outputs clear as above.
- in_ready = (state==IDLE). An op is accepted on a rising edge with in_valid & in_ready. in_valid is ignored when in_ready=0; there is no queuing.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 PASS(a)
  - 0110 SHL, 0111 SHR (logical), 1000 ASR, 1001 MUL
  - 1010-1111 undefined
- Single-cycle ops (everything except MUL):
  - result and flags are registered on the accepting edge; done=1 in the following cycle. Latency is 1.
  - The FSM stays in IDLE, so back-to-back accepts are allowed, one per cycle, each producing its own done pulse.
- Flag rules:
  - ADD: carry = bit WIDTH of a+b; overflow = operand signs equal and result sign differs.
  - SUB: carry = borrow (1 iff a<b unsigned); overflow = operand signs differ and result sign differs from a.
  - AND/OR/XOR/PASS: carry=0, overflow=0.
  - Shifts: amount = operand_b[SHW-1:0]; carry = last bit shifted out (0 when amount=0); overflow=0. ASR replicates the sign bit.
  - Undefined opcodes: result=0, result_hi=0, zero=1, other flags 0, done still pulses.
  - result_hi = 0 for every non-MUL op.
- FSM: IDLE, MUL.
  - IDLE -> MUL on accepting MUL. On that edge load multiplicand=a, multiplier=b, accumulator=0, count=0; set busy=1.
  - In MUL, each edge performs one unsigned shift-add step and count++.
  - On the WIDTH-th step edge, write {result_hi,result} = a*b (unsigned, 2*WIDTH bits), write flags, set busy=0, return to IDLE. done=1 in the next cycle.
  - MUL latency: done appears WIDTH edges after a single-cycle op accepted on the same edge would show it. in_ready=0 for exactly WIDTH cycles.
  - MUL flags: zero = full product==0; carry = (result_hi != 0); negative = result[WIDTH-1]; overflow=0.
- done is low whenever no operation completed on the preceding edge. Outputs are not disturbed by non-accepted in_valid.
- Operands are sampled only at accept. Changing inputs during MUL has no effect.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 -> result 0x00, Z=1 C=1 N=0 V=0; done one cycle after accept.
- SUB a=0x80 b=0x01 -> 0x7F, V=1 C=0 N=0; then SUB a=0x01 b=0x02 -> 0xFF, C=1 N=1 V=0.
- MUL a=0x0F b=0x11 -> result 0xFF, result_hi 0x00, C=0, Z=0. in_ready low exactly 8 cycles; in_valid pulsed mid-multiply is ignored. MUL 0xFF*0xFF -> result 0x01, result_hi 0xFE, C=1.
- Back-to-back ADD 0x03+0x04 then XOR 0x0F^0xFF on consecutive cycles -> done high two consecutive cycles with results 0x07 then 0xF0.
- SHL 0x81 by 1 -> 0x02, C=1; ASR 0x80 by 3 -> 0xF0, C=0, N=1; SHR 0x01 by 0 -> 0x01, C=0; opcode 1111 -> result 0, Z=1, done pulses.
- rst asserted 3 cycles into MUL -> next cycle busy=0, in_ready=1, all outputs 0, no done pulse; a following ADD completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU with NZCV flags, shifts and a multi-cycle shift-add multiply.
// Accepts one op per cycle through a valid/ready handshake; MUL stalls in_ready for WIDTH cycles.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             done,
   output logic             busy,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             negative_flag,
   output logic             overflow_flag
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned PW  = 2 * WIDTH;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_PASS = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_ASR  = 4'b1000;
   localparam logic [3:0] OP_MUL  = 4'b1001;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t            state;
   logic [PW-1:0]     mcand;
   logic [WIDTH-1:0]  mplier;
   logic [PW-1:0]     acc;
   logic [SHW-1:0]    count;

   logic [SHW-1:0]    shamt;
   logic [WIDTH:0]    sum_w;
   logic [WIDTH:0]    diff_w;
   logic [WIDTH:0]    shl_w;
   logic [WIDTH:0]    shr_w;
   logic signed [WIDTH:0] asr_w;

   logic [WIDTH-1:0]  alu_res;
   logic              alu_c;
   logic              alu_v;
   logic              alu_undef;

   logic [PW-1:0]     step_acc;
   logic              last_step;

   assign in_ready = (state == ST_IDLE);

   // Shifts carry one extra bit so the last bit shifted out falls out as the carry.
   assign shamt  = operand_b[SHW-1:0];
   assign sum_w  = {1'b0, operand_a} + {1'b0, operand_b};
   assign diff_w = {1'b0, operand_a} - {1'b0, operand_b};
   assign shl_w  = {1'b0, operand_a} << shamt;
   assign shr_w  = {operand_a, 1'b0} >> shamt;
   assign asr_w  = $signed({operand_a, 1'b0}) >>> shamt;

   // Single-cycle datapath result and carry/overflow.
   always_comb begin
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_undef = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum_w[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_c   = diff_w[WIDTH];
            alu_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (diff_w[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_AND:  alu_res = operand_a & operand_b;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_PASS: alu_res = operand_a;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[WIDTH:1];
            alu_c   = shr_w[0];
         end
         OP_ASR: begin
            alu_res = asr_w[WIDTH:1];
            alu_c   = asr_w[0];
         end
         OP_MUL:  alu_res = '0;
         default: alu_undef = 1'b1;
      endcase
   end

   assign step_acc  = acc + (mplier[0] ? mcand : PW'(0));
   assign last_step = (count == SHW'(WIDTH - 1));

   // Control FSM, multiply iteration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         count         <= '0;
         result        <= '0;
         result_hi     <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         zero_flag     <= 1'b0;
         carry_flag    <= 1'b0;
         negative_flag <= 1'b0;
         overflow_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (alu_op == OP_MUL) begin
                     mcand  <= PW'(operand_a);
                     mplier <= operand_b;
                     acc    <= '0;
                     count  <= '0;
                     busy   <= 1'b1;
                     state  <= ST_MUL;
                  end else begin
                     result        <= alu_res;
                     result_hi     <= '0;
                     zero_flag     <= alu_undef | (alu_res == '0);
                     carry_flag    <= alu_c;
                     negative_flag <= alu_res[WIDTH-1];
                     overflow_flag <= alu_v;
                     done          <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               acc    <= step_acc;
               mcand  <= {mcand[PW-2:0], 1'b0};
               mplier <= mplier >> 1;
               count  <= count + SHW'(1);
               if (last_step) begin
                  result        <= step_acc[WIDTH-1:0];
                  result_hi     <= step_acc[PW-1:WIDTH];
                  zero_flag     <= (step_acc == '0);
                  carry_flag    <= (step_acc[PW-1:WIDTH] != '0);
                  negative_flag <= step_acc[WIDTH-1];
                  overflow_flag <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases with literal expectations
// plus randomized traffic checked against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         done;
   logic         busy;
   logic         zero_flag;
   logic         carry_flag;
   logic         negative_flag;
   logic         overflow_flag;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_res, m_hi, m_left, p_res, p_hi;
   bit m_z, m_c, m_n, m_v, m_done, p_z, p_c, p_n;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
      .result(result), .result_hi(result_hi), .done(done), .busy(busy),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .negative_flag(negative_flag), .overflow_flag(overflow_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference evaluation of one op from the arithmetic definitions.
   task automatic model_op(input int op, input int a, input int b,
                           output int r, output bit z, output bit c, output bit v);
      int sa, sb, ss, sh;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      sh = b % W;
      r = 0; c = 0; v = 0;
      case (op)
         0: begin r = (a + b) % 256; c = (a + b) > 255; ss = sa + sb; v = (ss > 127) || (ss < -128); end
         1: begin r = (a - b + 256) % 256; c = a < b; ss = sa - sb; v = (ss > 127) || (ss < -128); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a;
         6: begin r = (a << sh) & 255; c = (sh != 0) && (((a >> (W - sh)) & 1) == 1); end
         7: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
         8: begin r = (sa >>> sh) & 255; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1); end
         default: r = 0;
      endcase
      z = (r == 0);
   endtask

   task automatic model_step(input logic r, input logic v, input int op, input int a, input int b);
      int tr; bit tz, tc, tv;
      if (r) begin
         m_res = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_done = 0; m_left = 0;
         return;
      end
      m_done = 0;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_res = p_res; m_hi = p_hi; m_z = p_z; m_c = p_c; m_n = p_n; m_v = 0; m_done = 1;
         end
      end else if (v) begin
         if (op == 9) begin
            p_res = (a * b) % 256; p_hi = (a * b) / 256;
            p_z = (a * b) == 0; p_c = p_hi != 0; p_n = p_res > 127;
            m_left = W;
         end else begin
            model_op(op, a, b, tr, tz, tc, tv);
            m_res = tr; m_hi = 0; m_z = tz; m_c = tc; m_n = tr > 127; m_v = tv; m_done = 1;
         end
      end
   endtask

   task automatic compare_all();
      chk("result", int'(result), m_res);
      chk("result_hi", int'(result_hi), m_hi);
      chk("zero", int'(zero_flag), int'(m_z));
      chk("carry", int'(carry_flag), int'(m_c));
      chk("negative", int'(negative_flag), int'(m_n));
      chk("overflow", int'(overflow_flag), int'(m_v));
      chk("done", int'(done), int'(m_done));
      chk("busy", int'(busy), int'(m_left > 0));
      chk("in_ready", int'(in_ready), int'(m_left == 0));
   endtask

   task automatic apply(input logic r, input logic v, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      rst = r; in_valid = v; alu_op = op; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      model_step(r, v, int'(op), int'(a), int'(b));
      compare_all();
   endtask

   initial begin
      int lowcnt;
      rst = 1'b1; in_valid = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0;
      apply(1, 1, 4'h0, 8'h11, 8'h22);
      apply(1, 0, 4'h0, 8'h00, 8'h00);
      chk("rst_result", int'(result), 0);
      chk("rst_ready", int'(in_ready), 1);
      apply(0, 0, 4'h0, 8'h00, 8'h00);
      chk("idle_ready", int'(in_ready), 1);

      // ADD wrap
      apply(0, 1, 4'h0, 8'hFF, 8'h01);
      chk("add_res", int'(result), 8'h00);
      chk("add_zc", int'({zero_flag, carry_flag, negative_flag, overflow_flag}), 4'b1100);
      chk("add_done", int'(done), 1);
      apply(0, 0, 4'h0, 8'h00, 8'h00);
      chk("done_drop", int'(done), 0);

      // SUB overflow and borrow
      apply(0, 1, 4'h1, 8'h80, 8'h01);
      chk("sub1_res", int'(result), 8'h7F);
      chk("sub1_nzcv", int'({negative_flag, zero_flag, carry_flag, overflow_flag}), 4'b0001);
      apply(0, 1, 4'h1, 8'h01, 8'h02);
      chk("sub2_res", int'(result), 8'hFF);
      chk("sub2_nzcv", int'({negative_flag, zero_flag, carry_flag, overflow_flag}), 4'b1010);

      // MUL with ready-low count and an ignored mid-multiply request
      apply(0, 1, 4'h9, 8'h0F, 8'h11);
      lowcnt = in_ready ? 0 : 1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) break;
         apply(0, (i == 3), 4'h0, 8'h55, 8'h66);
         if (!in_ready) lowcnt++;
      end
      chk("mul_ready_low", lowcnt, 8);
      chk("mul1_res", int'({result_hi, result}), 16'h00FF);
      chk("mul1_cz", int'({carry_flag, zero_flag}), 0);
      chk("mul1_done", int'(done), 1);
      apply(0, 0, 4'h0, 8'h00, 8'h00);
      chk("mul1_held", int'(result), 8'hFF);

      apply(0, 1, 4'h9, 8'hFF, 8'hFF);
      for (int i = 0; i < 20 && !in_ready; i++) apply(0, 0, 4'h0, 8'h00, 8'h00);
      chk("mul2_res", int'({result_hi, result}), 16'hFE01);
      chk("mul2_c", int'(carry_flag), 1);

      // Back-to-back single-cycle ops
      apply(0, 1, 4'h0, 8'h03, 8'h04);
      chk("b2b_res1", int'(result), 8'h07);
      chk("b2b_done1", int'(done), 1);
      apply(0, 1, 4'h4, 8'h0F, 8'hFF);
      chk("b2b_res2", int'(result), 8'hF0);
      chk("b2b_done2", int'(done), 1);

      // Shifts and undefined opcode
      apply(0, 1, 4'h6, 8'h81, 8'h01);
      chk("shl_res", int'({carry_flag, result}), 9'h102);
      apply(0, 1, 4'h8, 8'h80, 8'h03);
      chk("asr_res", int'({negative_flag, carry_flag, result}), 10'h2F0);
      apply(0, 1, 4'h7, 8'h01, 8'h00);
      chk("shr0_res", int'({carry_flag, result}), 9'h001);
      apply(0, 1, 4'hF, 8'h12, 8'h34);
      chk("undef_res", int'({done, zero_flag, result}), 10'h300);

      // Reset mid-multiply
      apply(0, 1, 4'h9, 8'h0F, 8'h11);
      apply(0, 0, 4'h0, 8'h00, 8'h00);
      apply(0, 0, 4'h0, 8'h00, 8'h00);
      apply(1, 0, 4'h0, 8'h00, 8'h00);
      chk("abort_state", int'({busy, in_ready, done, result}), 11'h200);
      apply(0, 1, 4'h0, 8'h03, 8'h04);
      chk("post_abort_add", int'({done, result}), 9'h107);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
               4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
